// File: rtl/ucsbece154b_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package ucsbece154b_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    // ResultSrc encodings driven by the decoder in E.
    typedef enum logic [SEL_W-1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    // Forwarding mux selects for the E-stage ALU operands.
    typedef enum logic [SEL_W-1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    // Memory-wait sequencing states.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Operand forwarding select; the younger producer in M wins over W.
    function automatic fwd_e fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_m,
        input logic             wr_m,
        input logic [REG_W-1:0] rd_w,
        input logic             wr_w
    );
        fwd_e sel;
        sel = FWD_RF;
        if (rs != REG_W'(0)) begin
            if (wr_m && (rs == rd_m)) begin
                sel = FWD_M;
            end else if (wr_w && (rs == rd_w)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
module ucsbece154b_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment when requested, holding at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ucsbece154b_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage RISC-V pipeline:
// forwarding, load-use stalls, branch flushes and data-memory wait freeze.
module ucsbece154b_hazard_ctrl
    import ucsbece154b_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TMR_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       Rs1E_i,
    input  logic [4:0]       Rs2E_i,
    input  logic [4:0]       RdE_i,
    input  logic [4:0]       RdM_i,
    input  logic [4:0]       RdW_i,
    input  logic             RegWriteM_i,
    input  logic             RegWriteW_i,
    input  logic [1:0]       ResultSrcE_i,
    input  logic             PCSrcE_i,
    input  logic             MemAccessM_i,
    input  logic             DMemReady_i,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             FlushW_o,
    output logic             DMemReq_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] LoadUseCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o,
    output logic [CNT_W-1:0] MemWaitCnt_o
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic        lw_stall_c;
    logic        mem_freeze_c;

    state_e           state_q;
    state_e           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             timeout_q;
    logic             timeout_d;

    // A load in E whose destination is read by the instruction in D.
    assign lw_stall_c = (ResultSrcE_i == RES_LOAD) && (RdE_i != 5'd0)
                     && ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));

    // Outstanding M-stage access; a zero-wait access never freezes.
    assign mem_freeze_c = MemAccessM_i && !DMemReady_i;

    // Forwarding, stall and flush controls, all forced low while in reset.
    // A freeze overrides flushes so a branch in E is kept and acted on later.
    always_comb begin
        ForwardAE_o = FWD_RF;
        ForwardBE_o = FWD_RF;
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;
        DMemReq_o   = 1'b0;
        if (!reset) begin
            ForwardAE_o = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
            ForwardBE_o = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
            StallF_o    = mem_freeze_c | lw_stall_c;
            StallD_o    = mem_freeze_c | lw_stall_c;
            StallE_o    = mem_freeze_c;
            StallM_o    = mem_freeze_c;
            FlushW_o    = mem_freeze_c;
            FlushD_o    = PCSrcE_i & !mem_freeze_c;
            FlushE_o    = (lw_stall_c | PCSrcE_i) & !mem_freeze_c;
            DMemReq_o   = MemAccessM_i;
        end
    end

    // Wait-state register, wait timer and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: time the wait; the timeout only flags, it never releases.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                timer_d = '0;
                if (mem_freeze_c) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                end
                if (!mem_freeze_c) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
        endcase
    end

    assign Timeout_o = timeout_q;

    // Load-use stall cycles that actually insert a bubble.
    ucsbece154b_sat_counter #(.W(CNT_W)) u_load_use_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (lw_stall_c & !mem_freeze_c),
        .count_o (LoadUseCnt_o)
    );

    // Branch/jump flush cycles that take effect.
    ucsbece154b_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (PCSrcE_i & !mem_freeze_c),
        .count_o (FlushCnt_o)
    );

    // Cycles spent frozen on data memory.
    ucsbece154b_sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (mem_freeze_c),
        .count_o (MemWaitCnt_o)
    );

endmodule

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Directed bench for the hazard controller (small counters, short timeout).
module tb_ucsbece154b_hazard_ctrl;
    import ucsbece154b_hazard_ctrl_pkg::*;

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned TMR_W   = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, MemAccessM, DMemReady;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             DMemReq, Timeout;
    logic [CNT_W-1:0] LoadUseCnt, FlushCnt, MemWaitCnt;

    int passed = 0;
    int total  = 0;

    ucsbece154b_hazard_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Rs1D_i       (Rs1D),
        .Rs2D_i       (Rs2D),
        .Rs1E_i       (Rs1E),
        .Rs2E_i       (Rs2E),
        .RdE_i        (RdE),
        .RdM_i        (RdM),
        .RdW_i        (RdW),
        .RegWriteM_i  (RegWriteM),
        .RegWriteW_i  (RegWriteW),
        .ResultSrcE_i (ResultSrcE),
        .PCSrcE_i     (PCSrcE),
        .MemAccessM_i (MemAccessM),
        .DMemReady_i  (DMemReady),
        .ForwardAE_o  (ForwardAE),
        .ForwardBE_o  (ForwardBE),
        .StallF_o     (StallF),
        .StallD_o     (StallD),
        .StallE_o     (StallE),
        .StallM_o     (StallM),
        .FlushD_o     (FlushD),
        .FlushE_o     (FlushE),
        .FlushW_o     (FlushW),
        .DMemReq_o    (DMemReq),
        .Timeout_o    (Timeout),
        .LoadUseCnt_o (LoadUseCnt),
        .FlushCnt_o   (FlushCnt),
        .MemWaitCnt_o (MemWaitCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
        PCSrcE = 1'b0; MemAccessM = 1'b0; DMemReady = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        MemAccessM = 1'b1; PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        #1;
        total++; if (ForwardAE !== 2'b00) $display("FAIL rst_fwdA: got %b exp 00", ForwardAE); else passed++;
        total++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) $display("FAIL rst_stall: got %b exp 0000", {StallF, StallD, StallE, StallM}); else passed++;
        total++; if ({FlushD, FlushE, FlushW, DMemReq} !== 4'b0000) $display("FAIL rst_flush_req: got %b exp 0000", {FlushD, FlushE, FlushW, DMemReq}); else passed++;
        @(posedge clk); #1;
        total++; if ({LoadUseCnt, FlushCnt, MemWaitCnt, Timeout} !== 10'd0) $display("FAIL rst_cnt: got %h exp 0", {LoadUseCnt, FlushCnt, MemWaitCnt, Timeout}); else passed++;
        do_reset();
    endtask

    task automatic test_forward();
        @(negedge clk);
        idle();
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd3;
        #1;
        total++; if (ForwardAE !== 2'b10) $display("FAIL fwd_m_prio: got %b exp 10", ForwardAE); else passed++;
        total++; if (ForwardBE !== 2'b00) $display("FAIL fwd_b_none: got %b exp 00", ForwardBE); else passed++;
        Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0;
        #1;
        total++; if (ForwardAE !== 2'b00) $display("FAIL fwd_x0: got %b exp 00", ForwardAE); else passed++;
        Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 1'b0; RdW = 5'd9; RegWriteW = 1'b1;
        #1;
        total++; if (ForwardBE !== 2'b01) $display("FAIL fwd_w_b: got %b exp 01", ForwardBE); else passed++;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b0; RdW = 5'd6;
        #1;
        total++; if (ForwardAE !== 2'b00) $display("FAIL fwd_nowr: got %b exp 00", ForwardAE); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        total++; if ({StallF, StallD, FlushE, FlushD, StallE} !== 5'b11100) $display("FAIL lu_ctrl: got %b exp 11100", {StallF, StallD, FlushE, FlushD, StallE}); else passed++;
        @(posedge clk); #1;
        total++; if (LoadUseCnt !== 3'd1) $display("FAIL lu_cnt1: got %0d exp 1", LoadUseCnt); else passed++;
        @(posedge clk); #1;
        total++; if (LoadUseCnt !== 3'd2) $display("FAIL lu_cnt2: got %0d exp 2", LoadUseCnt); else passed++;
        @(negedge clk);
        PCSrcE = 1'b1;
        #1;
        total++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1111) $display("FAIL lu_branch: got %b exp 1111", {StallF, StallD, FlushD, FlushE}); else passed++;
        @(posedge clk); #1;
        total++; if ({LoadUseCnt, FlushCnt} !== {3'd3, 3'd1}) $display("FAIL lu_branch_cnt: got %h exp %h", {LoadUseCnt, FlushCnt}, {3'd3, 3'd1}); else passed++;
        @(negedge clk);
        PCSrcE = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
        #1;
        total++; if ({StallF, FlushE} !== 2'b00) $display("FAIL lu_rd0: got %b exp 00", {StallF, FlushE}); else passed++;
        ResultSrcE = 2'b00; RdE = 5'd7; Rs1D = 5'd7;
        #1;
        total++; if ({StallF, FlushE} !== 2'b00) $display("FAIL lu_notload: got %b exp 00", {StallF, FlushE}); else passed++;
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        PCSrcE = 1'b1;
        #1;
        total++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) $display("FAIL br_ctrl: got %b exp 1100", {FlushD, FlushE, StallF, StallD}); else passed++;
        @(posedge clk); #1;
        total++; if (FlushCnt !== 3'd1) $display("FAIL br_cnt: got %0d exp 1", FlushCnt); else passed++;
        @(negedge clk);
        PCSrcE = 1'b0;
        #1;
        total++; if ({FlushD, FlushE} !== 2'b00) $display("FAIL br_done: got %b exp 00", {FlushD, FlushE}); else passed++;
        @(posedge clk); #1;
        total++; if (FlushCnt !== 3'd1) $display("FAIL br_cnt_hold: got %0d exp 1", FlushCnt); else passed++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        @(negedge clk);
        MemAccessM = 1'b1; DMemReady = 1'b0; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE, DMemReq} !== 8'b11111001)
                $display("FAIL mw_freeze%0d: got %b exp 11111001", i, {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE, DMemReq});
            else passed++;
            @(negedge clk);
        end
        DMemReady = 1'b1;
        #1;
        total++; if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE, DMemReq} !== 8'b00000111)
            $display("FAIL mw_release: got %b exp 00000111", {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE, DMemReq});
        else passed++;
        @(posedge clk); #1;
        total++; if (MemWaitCnt !== 3'd3) $display("FAIL mw_cnt: got %0d exp 3", MemWaitCnt); else passed++;
        total++; if (FlushCnt !== 3'd1) $display("FAIL mw_flushcnt: got %0d exp 1", FlushCnt); else passed++;
        total++; if (dut.state_q !== ST_RUN) $display("FAIL mw_state: got %b exp %b", dut.state_q, ST_RUN); else passed++;
        total++; if (Timeout !== 1'b0) $display("FAIL mw_no_timeout: got %b exp 0", Timeout); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        MemAccessM = 1'b1; DMemReady = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            total++; if (Timeout !== (k >= 5)) $display("FAIL to_edge%0d: got %b exp %b", k, Timeout, (k >= 5)); else passed++;
            total++; if (StallM !== 1'b1) $display("FAIL to_freeze%0d: got %b exp 1", k, StallM); else passed++;
        end
        total++; if (MemWaitCnt !== 3'd6) $display("FAIL to_cnt: got %0d exp 6", MemWaitCnt); else passed++;
        @(negedge clk);
        DMemReady = 1'b1;
        #1;
        total++; if (StallF !== 1'b0) $display("FAIL to_release: got %b exp 0", StallF); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        MemAccessM = 1'b0;
        @(posedge clk); #1;
        total++; if (Timeout !== 1'b1) $display("FAIL to_sticky: got %b exp 1", Timeout); else passed++;
    endtask

    task automatic test_async_reset_sat();
        @(negedge clk);
        idle();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
        repeat (9) @(posedge clk);
        #1;
        total++; if (LoadUseCnt !== 3'd7) $display("FAIL sat_lu: got %0d exp 7", LoadUseCnt); else passed++;
        @(negedge clk);
        idle();
        MemAccessM = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (MemWaitCnt !== 3'd7) $display("FAIL sat_mw: got %0d exp 7", MemWaitCnt); else passed++;
        total++; if (dut.state_q !== ST_WAIT) $display("FAIL ar_wait: got %b exp %b", dut.state_q, ST_WAIT); else passed++;
        #1;
        reset = 1'b1;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        #1;
        total++; if ({StallF, StallM, FlushW, DMemReq, ForwardAE} !== 6'd0) $display("FAIL ar_outs: got %b exp 000000", {StallF, StallM, FlushW, DMemReq, ForwardAE}); else passed++;
        total++; if ({LoadUseCnt, FlushCnt, MemWaitCnt, Timeout} !== 10'd0) $display("FAIL ar_regs: got %h exp 0", {LoadUseCnt, FlushCnt, MemWaitCnt, Timeout}); else passed++;
        total++; if (dut.state_q !== ST_RUN) $display("FAIL ar_state: got %b exp %b", dut.state_q, ST_RUN); else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if ({ForwardAE, StallM} !== 3'b101) $display("FAIL ar_resume: got %b exp 101", {ForwardAE, StallM}); else passed++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset_sat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
